ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit for the RV32I core: it holds the architectural PC register and issues word fetches to instruction memory. It returns each fetched instruction, tagged with its PC, to decode over a valid/ready handshake. It is the consumer of the next-PC selection logic: every taken branch or jump arrives here as a redirect, and sequential flow advances by 4. At most one memory request is outstanding, and any response belonging to a redirected-away path is discarded.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  ADDR_WIDTH  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_WIDTH  fetch address (current PC)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  DATA_WIDTH  fetched word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr_data  out  DATA_WIDTH  held instruction word
- instr_pc  out  ADDR_WIDTH  PC of held instruction
- fetch_fault  out  1  misaligned redirect target; fetch halted

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT. Internal registers: pc, discard flag, fault_pending flag.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, discard=0, fault_pending=0.
  - All outputs 0, except imem_req_addr, which shows pc (=RESET_PC).
- IDLE -> REQ unconditionally on the next cycle.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - On handshake (valid&&ready): go to WAIT.
  - Without a handshake, stay in REQ with the address held stable, unless a redirect occurs.
- WAIT:
  - Sample imem_rsp_valid.
  - Response with discard=0: instr_data<=imem_rsp_data, instr_pc<=pc, go to HOLD.
  - Response with discard=1: drop it and clear discard. Then go to FAULT if fault_pending, else REQ.
- HOLD:
  - instr_valid=1.
  - On instr_ready: pc<=pc+4, go to REQ.
- Redirect (redirect_valid=1), aligned target (redirect_pc[1:0]==0). pc<=redirect_pc in every case; per state:
  - REQ, no handshake: stay in REQ; the new address is presented next cycle.
  - REQ with handshake in the same cycle: the accepted request is stale. Go to WAIT with discard=1.
  - WAIT: set discard=1 and stay in WAIT. If the response arrives in the same cycle, drop it and go to REQ.
  - HOLD: the held instruction is dropped and instr_valid=0 next cycle; go to REQ. If instr_ready is also high, the handshake still counts as completed, but the pc+4 increment is overridden by redirect_pc.
  - IDLE: pc is loaded and the state goes to REQ.
- Misaligned redirect (redirect_pc[1:0]!=0): same as the aligned case, but the destination is FAULT instead of REQ. If a request is outstanding, set fault_pending=1 and enter FAULT after the stale response has been dropped.
- FAULT:
  - fetch_fault=1, imem_req_valid=0, instr_valid=0, pc holds the faulting target.
  - An aligned redirect clears fault_pending and goes to REQ.
  - A misaligned redirect stays in FAULT and loads the new pc.
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000), with no flag.

## Timing
- All outputs are driven from registers or decoded state only; there are no combinational input-to-output paths.
- Memory responses arrive no earlier than the cycle after the request handshake. Memory returns exactly one response per accepted request, in order.
- Sequential fetch with ready memory and decode: request at cycle t, response at t+1, instr_valid at t+2, next request at t+3.
- instr_valid, instr_data and instr_pc stay stable while in HOLD until the handshake or a redirect.
- A redirect takes effect on imem_req_addr the cycle after it is asserted. No instruction from the old path is presented after the redirect cycle.
- rst_n=0 in any state returns to the reset state at the next edge. Any in-flight response is ignored because the state is IDLE/REQ.

## Test plan
- Reset release, memory always ready, decode always ready, RESET_PC=0x0 -> request addresses 0x0, 0x4, 0x8; instr_pc matches each address; one instruction every 3 cycles.
- Decode stalled 5 cycles in HOLD at pc 0x10 -> instr_valid/instr_data/instr_pc stable; no new request until instr_ready; the next address is 0x14.
- Redirect to 0x200 in the WAIT cycle before the response of 0x40 -> the 0x40 response is dropped; the next request is 0x200; decode never sees pc 0x40.
- Redirect to 0x100 on the same cycle as the request handshake for 0x20 -> exactly one response is dropped; the next request is 0x100.
- Redirect to 0x102 -> fetch_fault=1, no requests; then redirect to 0x300 -> fetch_fault=0 next cycle and a request is issued to 0x300.
- RESET_PC=0xFFFFFFFC, sequential fetch -> the second request is 0x00000000; rst_n pulsed in HOLD -> instr_valid=0 and a restart at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the architectural PC, issues one word fetch at a time,
// and hands each returned instruction (tagged with its PC) to decode over valid/ready.
module ifetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    discard_q, discard_d;
    logic                    fault_pending_q, fault_pending_d;
    logic [DATA_WIDTH-1:0]   instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;

    logic                    misaligned;
    state_t                  redirect_dest;

    assign misaligned    = (redirect_pc[1:0] != 2'b00);
    assign redirect_dest = misaligned ? S_FAULT : S_REQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            discard_q       <= 1'b0;
            fault_pending_q <= 1'b0;
            instr_data_q    <= '0;
            instr_pc_q      <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            discard_q       <= discard_d;
            fault_pending_q <= fault_pending_d;
            instr_data_q    <= instr_data_d;
            instr_pc_q      <= instr_pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        discard_d       = discard_q;
        fault_pending_d = fault_pending_q;
        instr_data_d    = instr_data_q;
        instr_pc_d      = instr_pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redirect_dest;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_req_ready) begin
                        // The request just accepted belongs to the old path; its response must be dropped.
                        state_d         = S_WAIT;
                        discard_d       = 1'b1;
                        fault_pending_d = misaligned;
                    end else begin
                        state_d = redirect_dest;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        state_d         = redirect_dest;
                        discard_d       = 1'b0;
                        fault_pending_d = 1'b0;
                    end else begin
                        discard_d       = 1'b1;
                        fault_pending_d = misaligned;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d       = 1'b0;
                        fault_pending_d = 1'b0;
                        state_d         = fault_pending_q ? S_FAULT : S_REQ;
                    end else begin
                        instr_data_d = imem_rsp_data;
                        instr_pc_d   = pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect wins over the sequential increment even if decode accepts this cycle.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redirect_dest;
                end else if (instr_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_REQ;
                end
            end

            S_FAULT: begin
                if (redirect_valid) begin
                    pc_d            = redirect_pc;
                    state_d         = redirect_dest;
                    fault_pending_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr_data     = instr_data_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFC) share stimulus;
// use_b selects which one the checks observe.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_ready;

    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr_a, req_addr_b;
    logic        instr_valid_a, instr_valid_b;
    logic [31:0] instr_data_a, instr_data_b;
    logic [31:0] instr_pc_a, instr_pc_b;
    logic        fault_a, fault_b;

    logic        use_b;
    logic        o_req_valid, o_instr_valid, o_fault;
    logic [31:0] o_req_addr, o_instr_data, o_instr_pc;

    int n_cmp;
    int n_err;

    ifetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_a),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid_a), .instr_ready(instr_ready),
        .instr_data(instr_data_a), .instr_pc(instr_pc_a), .fetch_fault(fault_a)
    );

    ifetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready),
        .instr_data(instr_data_b), .instr_pc(instr_pc_b), .fetch_fault(fault_b)
    );

    assign o_req_valid   = use_b ? req_valid_b   : req_valid_a;
    assign o_req_addr    = use_b ? req_addr_b    : req_addr_a;
    assign o_instr_valid = use_b ? instr_valid_b : instr_valid_a;
    assign o_instr_data  = use_b ? instr_data_b  : instr_data_a;
    assign o_instr_pc    = use_b ? instr_pc_b    : instr_pc_a;
    assign o_fault       = use_b ? fault_b       : fault_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One sequential fetch with ready memory and decode: REQ, WAIT, HOLD, then back to REQ.
    task automatic fetch_seq(input logic [31:0] a);
        chk("req_valid", 32'(o_req_valid), 32'd1);
        chk("req_addr", o_req_addr, a);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(o_req_valid), 32'd0);
        chk("wait_instr_valid", 32'(o_instr_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(a);
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold_valid", 32'(o_instr_valid), 32'd1);
        chk("hold_pc", o_instr_pc, a);
        chk("hold_data", o_instr_data, word_at(a));
        chk("hold_req_valid", 32'(o_req_valid), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic redirect_now(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        use_b = 1'b0;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", 32'(req_valid_a), 32'd0);
        chk("rst_req_addr", req_addr_a, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid_a), 32'd0);
        chk("rst_instr_data", instr_data_a, 32'h0);
        chk("rst_instr_pc", instr_pc_a, 32'h0);
        chk("rst_fault", 32'(fault_a), 32'd0);
        chk("rst_req_addr_b", req_addr_b, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        tick();

        // Sequential fetch 0x0 .. 0xC, one instruction per 3 cycles
        fetch_seq(32'h0);
        fetch_seq(32'h4);
        fetch_seq(32'h8);
        fetch_seq(32'hC);

        // Decode stall in HOLD at 0x10
        chk("req_addr_10", o_req_addr, 32'h10);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h10);
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(o_instr_valid), 32'd1);
            chk("stall_pc", o_instr_pc, 32'h10);
            chk("stall_data", o_instr_data, word_at(32'h10));
            chk("stall_no_req", 32'(o_req_valid), 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("after_stall_valid", 32'(o_req_valid), 32'd1);
        chk("after_stall_addr", o_req_addr, 32'h14);

        // Memory not ready: request held stable
        tick();
        tick();
        chk("held_req_valid", 32'(o_req_valid), 32'd1);
        chk("held_req_addr", o_req_addr, 32'h14);

        // Redirect in REQ without handshake
        redirect_now(32'h40);
        chk("redir_req_addr", o_req_addr, 32'h40);
        chk("redir_req_valid", 32'(o_req_valid), 32'd1);

        // Redirect to 0x200 while waiting for the 0x40 response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_now(32'h200);
        chk("wait_redir_req_valid", 32'(o_req_valid), 32'd0);
        chk("wait_redir_addr", o_req_addr, 32'h200);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h40);
        tick();
        imem_rsp_valid = 1'b0;
        chk("drop40_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("drop40_req_valid", 32'(o_req_valid), 32'd1);
        chk("drop40_req_addr", o_req_addr, 32'h200);
        fetch_seq(32'h200);

        // Redirect to 0x100 on the cycle the 0x20 request is accepted
        redirect_now(32'h20);
        chk("req_addr_20", o_req_addr, 32'h20);
        imem_req_ready = 1'b1;
        redirect_now(32'h100);
        imem_req_ready = 1'b0;
        chk("hs_redir_req_valid", 32'(o_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h20);
        tick();
        imem_rsp_valid = 1'b0;
        chk("drop20_instr_valid", 32'(o_instr_valid), 32'd0);
        fetch_seq(32'h100);

        // Redirect in HOLD with instr_ready high: target overrides pc+4
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h104);
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold104_pc", o_instr_pc, 32'h104);
        instr_ready = 1'b1;
        redirect_now(32'h80);
        instr_ready = 1'b0;
        chk("hold_redir_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("hold_redir_addr", o_req_addr, 32'h80);

        // Misaligned redirect -> FAULT, no requests even with ready memory
        redirect_now(32'h102);
        imem_req_ready = 1'b1;
        chk("fault_flag", 32'(o_fault), 32'd1);
        chk("fault_no_req", 32'(o_req_valid), 32'd0);
        chk("fault_pc", o_req_addr, 32'h102);
        tick();
        tick();
        chk("fault_stays", 32'(o_fault), 32'd1);
        chk("fault_still_no_req", 32'(o_req_valid), 32'd0);
        imem_req_ready = 1'b0;
        redirect_now(32'h300);
        chk("unfault_flag", 32'(o_fault), 32'd0);
        chk("unfault_req_valid", 32'(o_req_valid), 32'd1);
        chk("unfault_addr", o_req_addr, 32'h300);

        // Misaligned redirect while a request is outstanding: FAULT after the drop
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_now(32'h306);
        chk("pend_no_fault_yet", 32'(o_fault), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h300);
        tick();
        imem_rsp_valid = 1'b0;
        chk("pend_fault", 32'(o_fault), 32'd1);
        chk("pend_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("pend_pc", o_req_addr, 32'h306);
        redirect_now(32'h0);
        chk("pend_clear_req", 32'(o_req_valid), 32'd1);

        // Wrap-around with RESET_PC = 0xFFFFFFFC, then reset pulse in HOLD
        use_b = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fetch_seq(32'hFFFF_FFFC);
        chk("wrap_addr", o_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        chk("wrap_hold_pc", o_instr_pc, 32'h0);
        rst_n = 1'b0;
        tick();
        chk("rst_hold_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_hold_req_valid", 32'(o_req_valid), 32'd0);
        chk("rst_hold_addr", o_req_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        tick();
        chk("restart_req_valid", 32'(o_req_valid), 32'd1);
        chk("restart_addr", o_req_addr, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
